quad_generator: RTL
===================

Name: quad_generator

Overview:
- Quadrature transmitter: drives an A/B pair so that a quadrature decoder of the same counting convention ends at a commanded WIDTH-bit value.
- Used as an on-chip emulator for the encoder inputs of the RGB mixer. Use cases: self-test loopback, scripted colour sequences, and bench stimulus for the debounce/decoder path.
- Accepts a target value over a valid/ready handshake.
- Walks the shortest modular path from the current position to the target, holding each phase long enough to pass the debouncers.

Parameters:
- WIDTH, 8, width of position/target; must match the decoder WIDTH.
- HOLD_CYCLES, 16, enabled clocks each A/B phase is held before the next transition; legal range 1..65535.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- ce  in  1  clock enable; the hold timer advances only on cycles with ce=1. Tie high for full rate.
- cmd_valid  in  1  target offered.
- cmd_ready  out  1  generator idle and able to accept a target.
- cmd_target  in  WIDTH  requested final position.
- a  out  1  quadrature channel A, registered.
- b  out  1  quadrature channel B, registered.
- position  out  WIDTH  count the decoder will read once the current phase settles, registered.
- busy  out  1  stepping in progress.
- done  out  1  one-clock pulse when a stepping command completes.

Behaviour:
- Reset, sampled on clk:
  - phase=0 (a=0, b=0), position=0, busy=0, done=0, timer=0.
  - cmd_ready=0 while reset is high, 1 on the first clock after release.
- Phase encoding, as {a,b}: 0=00, 1=10, 2=11, 3=01.
  - Forward step: phase+1 mod 4.
  - Reverse step: phase-1 mod 4.
- Counting convention, matching the decoder:
  - +1 counts on 00->10 and 11->01.
  - -1 counts on 00->01 and 11->10.
  - All other transitions do not count.
  - One count therefore equals two half-steps, starting and ending at an even phase. Phase is always even in IDLE.
- position updates:
  - Changes on the half-step that leaves an even phase: +1 forward, -1 reverse, wrapping mod 2^WIDTH.
  - The following half-step (odd to even) leaves position unchanged.
- State IDLE:
  - cmd_ready=1, busy=0.
  - Handshake completes when cmd_valid & cmd_ready. The target is latched and diff = (cmd_target - position) mod 2^WIDTH.
  - diff=0: remain IDLE and pulse done on the next clock.
  - diff otherwise: dir = forward if diff <= 2^(WIDTH-1), else reverse. An exact tie (diff = 2^(WIDTH-1)) goes forward. Then clear timer, go to RUN; cmd_ready drops and busy rises on the next clock.
- State RUN:
  - cmd_ready=0, busy=1. cmd_valid is ignored; no retargeting.
  - On each ce=1 cycle the timer increments.
  - When timer reaches HOLD_CYCLES-1 with ce=1: timer clears, phase steps in dir, position updates per the rule above.
  - First transition of a/b occurs HOLD_CYCLES enabled clocks after acceptance; each later half-step follows after another HOLD_CYCLES enabled clocks.
  - When a half-step lands on an even phase and position == target: go to IDLE on the same edge (busy=0, cmd_ready=1) and assert done for exactly one clock.
- ce=0 freezes timer, phase and position. Handshake and done are unaffected.
- Only one of a/b changes per transition; no glitch states. a and b come straight from flops.
- Reset mid-RUN: the next clock forces the full reset state. a/b return to 00 immediately, which may produce a spurious decoder count; the system resets the decoder in the same cycle.
- Total clocks for n counts with ce=1: 2*n*HOLD_CYCLES, with n <= 2^(WIDTH-1).

Test Plan:
1. Reset, then target 3, HOLD_CYCLES=4, ce=1 -> a/b sequence 00,10,11,01,00,10,11, each phase held 4 clocks; position 1,2,3 at the 1st, 3rd and 5th half-steps; done pulses at clock 24 after acceptance; ends with a=1, b=1.
2. From position 3, target 1 -> a/b sequence 11,10,00,01,11; position 2 then 1; done once; cmd_ready returns to 1.
3. From position 0, target 255 (WIDTH=8) -> reverse single count 00->01->11; position 255. From 0, target 128 -> forward 128 counts, done after 1024 clocks.
4. Loopback: outputs drive the debounce+decoder chain on the same clock, with HOLD_CYCLES > debounce history. Random targets -> decoder value equals target after each done.
5. cmd_valid asserted during RUN with a different target, and ce toggled 50% -> command ignored, original target reached; stepping takes 2x the clocks; target equal to position gives done with no a/b activity.
6. Reset asserted midway through test 1 -> next clock: a=b=0, position=0, busy=0, done=0; after release cmd_ready=1 and a new target completes normally.

Source files
------------

// File: rtl/quad_generator.sv
// quad_generator: quadrature transmitter that emulates a rotary encoder.
// It accepts a target over a valid/ready handshake. It then walks A/B along the
// shortest modular path until a matching decoder reads the target. Each phase is
// held for HOLD_CYCLES enabled clocks so that the debouncers see clean levels.
//
// Ports:
//   clk        clock
//   reset      synchronous, active-high reset
//   ce         clock enable for the hold timer (tie high for full rate)
//   cmd_valid  target offered
//   cmd_ready  idle and able to accept a target
//   cmd_target requested final position
//   a, b       quadrature outputs, taken directly from flops
//   position   count the decoder will read once the current phase settles
//   busy       stepping in progress
//   done       one-clock pulse when a command completes
module quad_generator #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned HOLD_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_target,
  output logic             a,
  output logic             b,
  output logic [WIDTH-1:0] position,
  output logic             busy,
  output logic             done
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  localparam logic [15:0]      HoldLast = 16'(HOLD_CYCLES - 1);
  localparam logic [WIDTH-1:0] Half     = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] One      = {{(WIDTH-1){1'b0}}, 1'b1};

  state_e           state;
  logic [WIDTH-1:0] target;
  logic             dir_fwd;
  logic [15:0]      timer;

  logic [WIDTH-1:0] diff;
  logic             accept;
  logic [1:0]       phase;
  logic [1:0]       next_phase;
  logic             at_even;

  always_comb begin
    diff   = cmd_target - position;
    accept = (state == StIdle) && cmd_valid && cmd_ready;
    // Gray sequence 00,10,11,01 maps to phase index {b, a^b}.
    phase      = {b, a ^ b};
    next_phase = dir_fwd ? phase + 2'd1 : phase - 2'd1;
    at_even    = (a == b);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= StIdle;
      a         <= 1'b0;
      b         <= 1'b0;
      position  <= '0;
      target    <= '0;
      dir_fwd   <= 1'b1;
      timer     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cmd_ready <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        StIdle: begin
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          if (accept) begin
            target <= cmd_target;
            if (diff == '0) begin
              done <= 1'b1;
            end else begin
              // An exact half-circle tie goes forward.
              dir_fwd   <= (diff <= Half);
              timer     <= '0;
              state     <= StRun;
              cmd_ready <= 1'b0;
              busy      <= 1'b1;
            end
          end
        end
        StRun: begin
          if (ce) begin
            if (timer == HoldLast) begin
              timer <= '0;
              a     <= next_phase[1] ^ next_phase[0];
              b     <= next_phase[1];
              if (at_even) begin
                // Leaving an even phase is where the decoder counts.
                position <= dir_fwd ? position + One : position - One;
              end else if (position == target) begin
                // Landing on an even phase with the count already at target.
                state     <= StIdle;
                busy      <= 1'b0;
                cmd_ready <= 1'b1;
                done      <= 1'b1;
              end
            end else begin
              timer <= timer + 16'd1;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
